// File: rtl/board_link_rx.sv
// rtl/board_link_rx.sv - inter-board link receive conditioning: sync, glitch filter, shot events
module board_link_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int CORD_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready_in,
  input  logic                  hit_in,
  input  logic [CORD_WIDTH-1:0] cords_in,
  output logic                  ready,
  output logic                  hit,
  output logic                  ready_rise,
  output logic                  ready_fall,
  output logic                  hit_rise,
  output logic [CORD_WIDTH-1:0] cords,
  output logic                  cords_valid,
  output logic [7:0]            reject_cnt
);

  localparam int         W    = CORD_WIDTH + 2;
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("board_link_rx: STABLE_CYCLES must be within 2..255");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("board_link_rx: SYNC_STAGES must be within 2..4");
  end

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    SETTLE     = 2'd1,
    ACCEPT     = 2'd2,
    HOLD       = 2'd3
  } state_t;

  logic [W-1:0]          sync_q [SYNC_STAGES];
  logic [W-1:0]          sync_out;
  logic                  lv_in   [2];
  logic                  lv_filt [2];
  logic [CORD_WIDTH-1:0] cd_sync;
  logic [CORD_WIDTH-1:0] cd_cand;
  logic [7:0]            cd_cnt;
  logic                  cd_last;
  logic                  cd_restart;
  logic                  cd_cnt_nz;
  logic                  ready_prev;
  logic                  hit_prev;
  logic                  accepted;
  state_t                state;
  state_t                state_nxt;

  // Plain flop chain per input bit; nothing sits between the stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {ready_in, hit_in, cords_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign lv_in[0] = sync_out[W-1];
  assign lv_in[1] = sync_out[W-2];
  assign cd_sync  = sync_out[CORD_WIDTH-1:0];

  // Lane 0 filters ready, lane 1 filters hit
  for (genvar g = 0; g < 2; g++) begin : g_lv
    logic       cand_q;
    logic [7:0] cnt_q;
    logic       filt_q;

    // Restart on any change, otherwise count up; publish once the run is long enough
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cand_q <= 1'b0;
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        if (lv_in[g] != cand_q) begin
          cand_q <= lv_in[g];
          cnt_q  <= '0;
        end else if (cnt_q != LAST) begin
          cnt_q <= cnt_q + 8'd1;
        end
        if (cnt_q == LAST) filt_q <= cand_q;
      end
    end

    assign lv_filt[g] = filt_q;
  end

  // Coordinate stability tracker; the FSM consumes candidate and run length directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_cand <= '0;
      cd_cnt  <= '0;
    end else if (cd_restart) begin
      cd_cand <= cd_sync;
      cd_cnt  <= '0;
    end else if (!cd_last) begin
      cd_cnt <= cd_cnt + 8'd1;
    end
  end

  assign cd_last    = (cd_cnt == LAST);
  assign cd_restart = (cd_sync != cd_cand);
  assign cd_cnt_nz  = (cd_cnt != 8'd0);

  assign ready = lv_filt[0];
  assign hit   = lv_filt[1];

  // Previous filtered levels for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_prev <= 1'b0;
      hit_prev   <= 1'b0;
    end else begin
      ready_prev <= ready;
      hit_prev   <= hit;
    end
  end

  assign ready_rise = ready & ~ready_prev;
  assign ready_fall = ~ready & ready_prev;
  assign hit_rise   = hit & ~hit_prev;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_READY;
    else      state <= state_nxt;
  end

  // FSM next state; a ready drop overrides everything, including ACCEPT
  always_comb begin
    state_nxt = state;
    if (ready_fall) begin
      state_nxt = WAIT_READY;
    end else begin
      case (state)
        WAIT_READY: if (ready) state_nxt = SETTLE;
        SETTLE: begin
          if (cd_last) begin
            if (!accepted || (cd_cand != cords)) state_nxt = ACCEPT;
            else                                 state_nxt = HOLD;
          end
        end
        ACCEPT:  state_nxt = HOLD;
        HOLD:    if (cd_restart) state_nxt = SETTLE;
        default: state_nxt = WAIT_READY;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    cords_valid = 1'b0;
    if (state == ACCEPT && !ready_fall) cords_valid = 1'b1;
  end

  // Accepted coordinate and the once-per-ready-period flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cords    <= '0;
      accepted <= 1'b0;
    end else if (ready_fall) begin
      accepted <= 1'b0;
    end else if (cords_valid) begin
      cords    <= cd_cand;
      accepted <= 1'b1;
    end
  end

  // Count coordinate runs that were broken while waiting to settle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reject_cnt <= '0;
    end else if (state == SETTLE && cd_restart && cd_cnt_nz && reject_cnt != 8'hFF) begin
      reject_cnt <= reject_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_board_link_rx.sv
// tb/tb_board_link_rx.sv - self-checking bench for board_link_rx against a window-based model
module tb_board_link_rx;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int CW     = 8;

  localparam int M_WAIT   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_ACCEPT = 2;
  localparam int M_HOLD   = 3;

  typedef struct packed {
    logic          r;
    logic          h;
    logic [CW-1:0] c;
  } samp_t;

  logic          clk;
  logic          rst;
  logic          ready_in;
  logic          hit_in;
  logic [CW-1:0] cords_in;
  logic          ready;
  logic          hit;
  logic          ready_rise;
  logic          ready_fall;
  logic          hit_rise;
  logic [CW-1:0] cords;
  logic          cords_valid;
  logic [7:0]    reject_cnt;

  int n_checks;
  int n_errors;

  samp_t dq[$];
  samp_t syq[$];
  logic          m_ready, m_rprev, m_hit, m_hprev, m_acc;
  logic [CW-1:0] m_cords;
  int            m_state;
  int            m_rej;

  int cnt_valid, cnt_rr, cnt_rf, cnt_hr;

  board_link_rx #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CORD_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready_in   (ready_in),
    .hit_in     (hit_in),
    .cords_in   (cords_in),
    .ready      (ready),
    .hit        (hit),
    .ready_rise (ready_rise),
    .ready_fall (ready_fall),
    .hit_rise   (hit_rise),
    .cords      (cords),
    .cords_valid(cords_valid),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] fld(samp_t s, int f);
    if (f == 0) return {7'd0, s.r};
    if (f == 1) return {7'd0, s.h};
    return s.c;
  endfunction

  // True when the last STABLE synchronised samples before the newest one all agree
  function automatic logic win_stable(int f);
    int n;
    logic [7:0] v;
    n = syq.size();
    if (n < STABLE + 1) return 1'b0;
    v = fld(syq[n-2], f);
    for (int i = n - 1 - STABLE; i <= n - 2; i++)
      if (fld(syq[i], f) != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic reset_model();
    samp_t z;
    z = '0;
    dq.delete();
    syq.delete();
    for (int i = 0; i < SYNC; i++) dq.push_back(z);
    syq.push_back(z);
    syq.push_back(z);
    m_ready = 0; m_rprev = 0; m_hit = 0; m_hprev = 0; m_acc = 0;
    m_cords = '0; m_state = M_WAIT; m_rej = 0;
  endtask

  // Advance the model by one rising edge, using only pre-edge model values
  task automatic model_step();
    samp_t cur, cnd, t;
    logic rfall, st_c, rst_c, nz_c, nr, nh;
    int n, ns;
    n     = syq.size();
    cur   = syq[n-1];
    cnd   = syq[n-2];
    rfall = !m_ready && m_rprev;
    st_c  = win_stable(2);
    rst_c = (cur.c != cnd.c);
    nz_c  = (n >= 3) && (syq[n-2].c == syq[n-3].c);
    if (m_state == M_SETTLE && rst_c && nz_c && m_rej < 255) m_rej++;
    ns = m_state;
    if (rfall) begin
      ns = M_WAIT;
      m_acc = 0;
    end else begin
      case (m_state)
        M_WAIT:   if (m_ready) ns = M_SETTLE;
        M_SETTLE: if (st_c) ns = (!m_acc || cnd.c != m_cords) ? M_ACCEPT : M_HOLD;
        M_ACCEPT: begin m_cords = cnd.c; m_acc = 1; ns = M_HOLD; end
        default:  if (rst_c) ns = M_SETTLE;
      endcase
    end
    m_state = ns;
    nr = win_stable(0) ? cnd.r : m_ready;
    nh = win_stable(1) ? cnd.h : m_hit;
    m_rprev = m_ready; m_ready = nr;
    m_hprev = m_hit;   m_hit   = nh;
    t.r = ready_in; t.h = hit_in; t.c = cords_in;
    dq.push_back(t);
    void'(dq.pop_front());
    syq.push_back(dq[0]);
    if (syq.size() > STABLE + 4) void'(syq.pop_front());
  endtask

  task automatic compare_all();
    logic efall;
    efall = !m_ready && m_rprev;
    check("ready", ready, m_ready);
    check("hit", hit, m_hit);
    check("ready_rise", ready_rise, m_ready && !m_rprev);
    check("ready_fall", ready_fall, efall);
    check("hit_rise", hit_rise, m_hit && !m_hprev);
    check("cords", cords, m_cords);
    check("cords_valid", cords_valid, (m_state == M_ACCEPT) && !efall);
    check("reject_cnt", reject_cnt, m_rej);
    if (cords_valid) cnt_valid++;
    if (ready_rise)  cnt_rr++;
    if (ready_fall)  cnt_rf++;
    if (hit_rise)    cnt_hr++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_counts();
    cnt_valid = 0; cnt_rr = 0; cnt_rf = 0; cnt_hr = 0;
  endtask

  logic [CW-1:0] nv;
  int first_at, hold, r_hold, h_hold, c_hold, done;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    ready_in = 1'b0; hit_in = 1'b0; cords_in = '0;
    reset_model();
    clear_counts();
    repeat (2) @(negedge clk);
    ready_in = 1'b1; hit_in = 1'b1; cords_in = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_hit", hit, 0);
    check("rst_pulses", {ready_rise, ready_fall, hit_rise}, 0);
    check("rst_cords", cords, 0);
    check("rst_valid", cords_valid, 0);
    check("rst_reject", reject_cnt, 0);

    // Release with ready high and a clean shot already on the bus
    hit_in = 1'b0; cords_in = 8'h35; rst = 1'b1;
    first_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready === 1'b1 && first_at == 0) first_at = i;
    end
    check("ready_latency", first_at, 11);
    check("ready_rise_once", cnt_rr, 1);
    check("shot_valid_once", cnt_valid, 1);
    check("shot_cords", cords, 8'h35);
    clear_counts();
    repeat (100) step();
    check("shot_no_repeat", cnt_valid, 0);

    // Short glitch on the coordinate bus after acceptance
    clear_counts();
    cords_in = 8'h36;
    repeat (3) step();
    cords_in = 8'h35;
    repeat (40) step();
    check("glitch_no_valid", cnt_valid, 0);
    check("glitch_cords", cords, 8'h35);

    // Ready low/high cycle re-accepts the same coordinate once
    clear_counts();
    ready_in = 1'b0;
    repeat (20) step();
    ready_in = 1'b1;
    repeat (60) step();
    check("recycle_fall", cnt_rf, 1);
    check("recycle_rise", cnt_rr, 1);
    check("recycle_valid", cnt_valid, 1);
    check("recycle_cords", cords, 8'h35);

    // Ready drop lands on the ACCEPT cycle of a new coordinate
    clear_counts();
    cords_in = 8'h7A; ready_in = 1'b0;
    repeat (40) step();
    check("drop_no_valid", cnt_valid, 0);
    check("drop_cords", cords, 8'h35);
    check("drop_fall", cnt_rf, 1);

    // Hit path: short pulse filtered, long pulse passed
    clear_counts();
    hit_in = 1'b1;
    repeat (5) step();
    hit_in = 1'b0;
    repeat (30) step();
    check("hit_short", cnt_hr, 0);
    hit_in = 1'b1;
    first_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 20) hit_in = 1'b0;
      if (hit === 1'b1 && first_at == 0) first_at = i;
    end
    check("hit_latency", first_at, 11);
    check("hit_rise_once", cnt_hr, 1);

    // Randomised traffic on all three lines
    r_hold = 0; h_hold = 0; c_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (r_hold == 0) begin ready_in = 1'($urandom_range(0, 1)); r_hold = $urandom_range(5, 60); end
      else r_hold--;
      if (h_hold == 0) begin hit_in = 1'($urandom_range(0, 1)); h_hold = $urandom_range(1, 15); end
      else h_hold--;
      if (c_hold == 0) begin
        case ($urandom_range(0, 3))
          0:       cords_in = 8'h35;
          1:       cords_in = 8'h36;
          2:       cords_in = 8'h7A;
          default: cords_in = 8'($urandom);
        endcase
        c_hold = $urandom_range(1, 14);
      end else c_hold--;
      step();
    end

    // Unsettled coordinates with ready high drive the reject counter to saturation
    ready_in = 1'b1; hit_in = 1'b0; cords_in = 8'h35;
    repeat (30) step();
    done = 0;
    while (done < 1200) begin
      nv = 8'($urandom);
      if (nv == cords_in) nv = nv ^ 8'h01;
      cords_in = nv;
      hold = $urandom_range(2, 4);
      repeat (hold) step();
      done += hold;
    end
    check("reject_saturated", reject_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
